// File: rtl/vga_timing_if.sv
// vga_timing_if: raster outputs from the timing generator to the DAC pins and bitgen.
interface vga_timing_if;
  logic       vga_clk;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic       frame_start;
  logic [9:0] hcount;
  logic [9:0] vcount;
  modport master (output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, hcount, vcount);
  modport slave (input vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, hcount, vcount);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: clk/2 pixel clock and 640x480@60 raster counters with registered sync/blank decodes.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input logic         clk,
  input logic         reset,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  logic       d_q;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hs_q, vs_q, blank_n_q, fs_q;
  always_comb begin
    h_d = !d_q ? h_q : (h_q == H_LAST) ? '0 : h_q + 10'd1;
    v_d = (!d_q || h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 10'd1;
  end
  // Decodes use next-state counters so they line up with the counters shown in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q       <= 1'b0;
      h_q       <= H_LAST;
      v_q       <= V_LAST;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      d_q       <= !d_q;
      h_q       <= h_d;
      v_q       <= v_d;
      hs_q      <= !(h_d >= HS_ON && h_d <= HS_END);
      vs_q      <= !(v_d >= VS_ON && v_d <= VS_END);
      blank_n_q <= (h_d < H_VIS) && (v_d < V_VIS);
      fs_q      <= (h_d == '0) && (v_d == '0);
    end
  end
  assign vga.vga_clk     = d_q;
  assign vga.vga_hs      = hs_q;
  assign vga.vga_vs      = vs_q;
  assign vga.vga_blank_n = blank_n_q;
  assign vga.vga_sync_n  = 1'b0;
  assign vga.frame_start = fs_q;
  assign vga.hcount      = h_q;
  assign vga.vcount      = v_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed vector checks of the default raster plus a tiny overridden raster.
module tb_vga_timing;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;
  vga_timing_if va();
  vga_timing_if vb();
  vga_timing ua (.clk(clk), .reset(rst_a), .vga(va));
  vga_timing #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
               .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1))
    ub (.clk(clk), .reset(rst_b), .vga(vb));
  typedef struct {
    int e;
    int h;
    int v;
    bit hs;
    bit vs;
    bit bl;
    bit fs;
    bit vc;
  } vec_t;
  vec_t tbl[12];
  int checks = 0;
  int errors = 0;
  int ed = 0;
  logic hs_prev_a = 1'b1, hs_prev_b = 1'b1, fs_prev_b = 1'b0;
  int falls_a[$];
  int falls_b[$];
  int fsr_b[$];
  function automatic vec_t mk(int e, int h, int v, bit hs, bit vs, bit bl, bit fs, bit vc);
    vec_t r;
    r.e = e; r.h = h; r.v = v; r.hs = hs; r.vs = vs; r.bl = bl; r.fs = fs; r.vc = vc;
    return r;
  endfunction
  function automatic vec_t snap_a();
    return mk(ed, int'(va.hcount), int'(va.vcount), va.vga_hs, va.vga_vs, va.vga_blank_n, va.frame_start, va.vga_clk);
  endfunction
  function automatic vec_t snap_b();
    return mk(ed, int'(vb.hcount), int'(vb.vcount), vb.vga_hs, vb.vga_vs, vb.vga_blank_n, vb.frame_start, vb.vga_clk);
  endfunction
  task automatic chk(string nm, vec_t g, vec_t x, logic sync_n);
    checks++;
    if (g.h != x.h || g.v != x.v || g.hs != x.hs || g.vs != x.vs || g.bl != x.bl ||
        g.fs != x.fs || g.vc != x.vc || sync_n !== 1'b0) begin
      errors++;
      $display("FAIL %s edge %0d: got h=%0d v=%0d hs=%0b vs=%0b bl=%0b fs=%0b vc=%0b sn=%0b want h=%0d v=%0d hs=%0b vs=%0b bl=%0b fs=%0b vc=%0b sn=0",
               nm, ed, g.h, g.v, g.hs, g.vs, g.bl, g.fs, g.vc, sync_n, x.h, x.v, x.hs, x.vs, x.bl, x.fs, x.vc);
    end
  endtask
  task automatic chk_int(string nm, int g, int x);
    checks++;
    if (g != x) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, g, x);
    end
  endtask
  task automatic step();
    @(negedge clk);
    ed++;
    if (hs_prev_a && !va.vga_hs) falls_a.push_back(ed);
    if (hs_prev_b && !vb.vga_hs) falls_b.push_back(ed);
    if (!fs_prev_b && vb.frame_start) fsr_b.push_back(ed);
    hs_prev_a = va.vga_hs;
    hs_prev_b = vb.vga_hs;
    fs_prev_b = vb.frame_start;
  endtask
  task automatic run_tbl(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      while (ed < tbl[i].e) step();
      chk($sformatf("tbl%0d", i), snap_a(), tbl[i], va.vga_sync_n);
    end
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t rst_vec_a, rst_vec_b, xb;
    int vs_low;
    tbl[0]  = mk(1,    799, 524, 1, 1, 0, 0, 1);
    tbl[1]  = mk(2,    0,   0,   1, 1, 1, 1, 0);
    tbl[2]  = mk(3,    0,   0,   1, 1, 1, 1, 1);
    tbl[3]  = mk(4,    1,   0,   1, 1, 1, 0, 0);
    tbl[4]  = mk(1281, 639, 0,   1, 1, 1, 0, 1);
    tbl[5]  = mk(1282, 640, 0,   1, 1, 0, 0, 0);
    tbl[6]  = mk(1313, 655, 0,   1, 1, 0, 0, 1);
    tbl[7]  = mk(1314, 656, 0,   0, 1, 0, 0, 0);
    tbl[8]  = mk(1505, 751, 0,   0, 1, 0, 0, 1);
    tbl[9]  = mk(1506, 752, 0,   1, 1, 0, 0, 0);
    tbl[10] = mk(1601, 799, 0,   1, 1, 0, 0, 1);
    tbl[11] = mk(1602, 0,   1,   1, 1, 1, 0, 0);
    rst_vec_a = mk(0, 799, 524, 1, 1, 0, 0, 0);
    rst_vec_b = mk(0, 15, 6, 1, 1, 0, 0, 0);
    repeat (5) begin
      step();
      chk("reset_a", snap_a(), rst_vec_a, va.vga_sync_n);
      chk("reset_b", snap_b(), rst_vec_b, vb.vga_sync_n);
    end
    // Overridden raster: 16x7 pixels, checked every edge against a pixel-index model.
    rst_b = 1'b0;
    ed = 0;
    falls_b.delete();
    fsr_b.delete();
    vs_low = 0;
    for (int k = 1; k <= 480; k++) begin
      int n, h, v;
      step();
      n = (k - 2) / 2;
      h = (k < 2) ? 15 : n % 16;
      v = (k < 2) ? 6 : (n / 16) % 7;
      xb = mk(k, h, v, !(h >= 10 && h <= 12), v != 5, h < 8 && v < 4, h == 0 && v == 0 && k >= 2, k % 2 == 1);
      chk("small_raster", snap_b(), xb, vb.vga_sync_n);
      if (k >= 2 && k <= 225 && !vb.vga_vs) vs_low++;
    end
    rst_b = 1'b1;
    chk_int("small_hs_first_fall", falls_b.size() > 0 ? falls_b[0] : -1, 22);
    chk_int("small_line_clk", falls_b.size() > 1 ? falls_b[1] - falls_b[0] : -1, 32);
    chk_int("small_frame_clk", fsr_b.size() > 1 ? fsr_b[1] - fsr_b[0] : -1, 224);
    chk_int("small_vs_low_clk", vs_low, 32);
    // Default raster: first pixel and the horizontal decode boundaries.
    rst_a = 1'b0;
    ed = 0;
    falls_a.delete();
    run_tbl(0, 11);
    while (ed < 4600) step();
    chk_int("hs_fall_count", falls_a.size(), 3);
    chk_int("hs_first_fall", falls_a.size() > 0 ? falls_a[0] : -1, 1314);
    chk_int("hs_spacing1", falls_a.size() > 1 ? falls_a[1] - falls_a[0] : -1, 1600);
    chk_int("hs_spacing2", falls_a.size() > 2 ? falls_a[2] - falls_a[1] : -1, 1600);
    // Mid-frame reset at (320,3) with the divider high, so the next edge would have been a tick.
    while (ed < 5443) step();
    chk("mid_before", snap_a(), mk(5443, 320, 3, 1, 1, 1, 0, 1), va.vga_sync_n);
    rst_a = 1'b1;
    step();
    chk("mid_reset", snap_a(), rst_vec_a, va.vga_sync_n);
    rst_a = 1'b0;
    ed = 0;
    run_tbl(0, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the VGA output path. It divides the 50 MHz board clock into a 25 MHz pixel clock and scans a 640x480@60 Hz frame. It drives the DAC-side sync and clock pins and publishes `vga_blank_n` plus the current pixel coordinates. The pixel generators (bitgen) consume `vga_blank_n`, `hcount` and `vcount` to produce r/g/b.

## Interface
- `H_VISIBLE`, default 640: visible pixels per line
- `H_FRONT`, default 16: horizontal front porch, in pixels
- `H_SYNC`, default 96: hsync pulse width, in pixels
- `H_BACK`, default 48: horizontal back porch, in pixels
- `V_VISIBLE`, default 480: visible lines per frame
- `V_FRONT`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vsync pulse width, in lines
- `V_BACK`, default 33: vertical back porch, in lines
- `clk` in 1: 50 MHz system clock
- `reset` in 1: synchronous, active-high
- `vga_clk` out 1: pixel clock to the DAC (clk/2)
- `vga_hs` out 1: horizontal sync, active-low
- `vga_vs` out 1: vertical sync, active-low
- `vga_blank_n` out 1: high when the pixel is in the visible region
- `vga_sync_n` out 1: tied 0 (no sync-on-green)
- `hcount` out 10: current pixel column, 0..H_TOTAL-1
- `vcount` out 10: current line, 0..V_TOTAL-1
- `frame_start` out 1: high while (`hcount`,`vcount`) == (0,0)

## Operation
- Derived totals:
  - H_TOTAL = sum of the H_* parameters, 800 by default.
  - V_TOTAL = sum of the V_* parameters, 525 by default.
  - Both totals must be ≤1024.
- Divider bit `d`:
  - Reset value 0; toggles every clk.
  - `vga_clk` = `d`.
  - A pixel tick is any clk edge where `d` == 1 before the edge.
- On a pixel tick:
  - `hcount` increments.
  - At H_TOTAL-1 it wraps to 0, and `vcount` increments.
  - At V_TOTAL-1 `vcount` wraps to 0.
  - Counters hold on non-tick edges.
- Decodes, using defaults:
  - `vga_hs` = 0 iff `hcount` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656,751].
  - `vga_vs` = 0 iff `vcount` in [490,491].
  - `vga_blank_n` = 1 iff `hcount` < 640 and `vcount` < 480.
  - `frame_start` = 1 iff `hcount` == 0 and `vcount` == 0.
- All outputs are registered, with no combinational paths from counters to pins. Every decode is consistent with the `hcount`/`vcount` values shown in the same cycle, so registered outputs are computed from the next-state counters.
- Reset:
  - `hcount` = H_TOTAL-1 (799), `vcount` = V_TOTAL-1 (524).
  - `d` = 0, `vga_clk` = 0.
  - `vga_hs` = 1, `vga_vs` = 1, `vga_blank_n` = 0, `frame_start` = 0, `vga_sync_n` = 0.
  - These values are consistent with the decode of (799,524), so the first tick after reset wraps cleanly to (0,0).
- Reset asserted mid-frame: all state returns to reset values on the next clk edge, regardless of `d`. No partial line or pulse persists.

## Timing
- After `reset` deasserts, it takes 2 clk edges to reach (0,0):
  - edge 1: `d` goes 0→1.
  - edge 2: tick; counters become (0,0); `vga_blank_n` = 1; `frame_start` = 1.
- Each pixel lasts 2 clk. A line is 1600 clk; a frame is 840 000 clk (59.52 Hz at 50 MHz).
- `hcount`/`vcount` and all decodes change only on the edge where `vga_clk` falls (1→0). They are therefore stable across the following `vga_clk` rising edge, where the DAC samples.
- `frame_start` is high for exactly 2 clk per frame.
- The hsync pulse lasts 96 px (192 clk). The vsync pulse lasts 2 lines (3200 clk). Both pulses begin on a pixel-tick edge.

## Test plan
- Reset: hold `reset` 5 clk. Required during and 1 clk after: (`hcount`,`vcount`) = (799,524), `vga_hs` = 1, `vga_vs` = 1, `vga_blank_n` = 0, `vga_clk` = 0, `vga_sync_n` = 0.
- First pixel: release `reset`. At edge 2 the block shows (0,0), `vga_blank_n` = 1, `frame_start` = 1; at edge 4 it shows (1,0) and `frame_start` = 0.
- Horizontal line: `vga_blank_n` falls when `hcount` becomes 640, `vga_hs` falls at 656 and rises at 752, and `hcount` wraps 799→0 with `vcount` +1. The spacing between successive hsync falling edges is 1600 clk.
- Vertical frame: `vga_vs` is low exactly while `vcount` ∈ {490,491}, `vga_blank_n` stays 0 for `vcount` 480..524, and the spacing between successive `frame_start` rising edges is 840 000 clk.
- Mid-frame reset: assert `reset` for 1 clk at (320,240) while `vga_blank_n` = 1. Next edge: (799,524) and `vga_blank_n` = 0. After release, the sequence from scenario 2 repeats.
- Parameter override (H_VISIBLE = 8, H_FRONT = 2, H_SYNC = 3, H_BACK = 3, V_VISIBLE = 4, V_FRONT = 1, V_SYNC = 1, V_BACK = 1): line = 32 clk, hsync low for `hcount` 10..12, frame = 224 clk.
